// File: rtl/l2_fill_arbiter.sv
// l2_fill_arbiter
// Shares one memory read-address channel among the line-fill request ports of
// N_REQ tiles using round-robin arbitration. Read data is steered back to the
// requesting tile by the requester index carried in the upper ID bits.
// Each requester may have at most 2^LOG_N_MSHR fills in flight.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   req_valid/ready/addr/id        per-tile fill request channel (packed buses)
//   mem_ar{valid,ready,addr,id}    registered read-address channel to memory
//   mem_r{valid,ready,id,data}     read-data channel from memory
//   resp_valid/ready, resp_id/data one-hot response valid, shared id/data bus
//   err_underflow                  sticky: response with nothing outstanding,
//                                  or response ID naming a non-existent tile
//   stall_cycles                   saturating count of cycles where some request
//                                  was pending but none was accepted
module l2_fill_arbiter #(
    parameter int N_REQ            = 4,
    parameter int LOG_N_MSHR       = 4,
    parameter int ADDR_BITS        = 34,
    parameter int CACHE_BYTE_WIDTH = 6,
    parameter int DATA_W           = 512,
    localparam int LOG_REQ         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ*ADDR_BITS-1:0]      req_addr,
    input  logic [N_REQ*LOG_N_MSHR-1:0]     req_id,
    output logic                            mem_arvalid,
    input  logic                            mem_arready,
    output logic [ADDR_BITS-1:0]            mem_araddr,
    output logic [LOG_REQ+LOG_N_MSHR-1:0]   mem_arid,
    input  logic                            mem_rvalid,
    output logic                            mem_rready,
    input  logic [LOG_REQ+LOG_N_MSHR-1:0]   mem_rid,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [N_REQ-1:0]                resp_valid,
    input  logic [N_REQ-1:0]                resp_ready,
    output logic [LOG_N_MSHR-1:0]           resp_id,
    output logic [DATA_W-1:0]               resp_data,
    output logic                            err_underflow,
    output logic [31:0]                     stall_cycles
);

    localparam int ID_W  = LOG_REQ + LOG_N_MSHR;
    localparam int CNT_W = LOG_N_MSHR + 1;

    // Clears the byte-offset bits so memory always sees a line-aligned address.
    function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] addr);
        return {addr[ADDR_BITS-1:CACHE_BYTE_WIDTH], {CACHE_BYTE_WIDTH{1'b0}}};
    endfunction

    logic [CNT_W-1:0]     outstanding_r [N_REQ];
    logic [LOG_REQ-1:0]   rr_ptr_r;
    logic                 ar_valid_r;
    logic [ADDR_BITS-1:0] ar_addr_r;
    logic [ID_W-1:0]      ar_id_r;
    logic                 err_r;
    logic [31:0]          stall_r;

    logic                 load_s;
    logic [N_REQ-1:0]     eligible_s;
    logic                 grant_found_s;
    logic [LOG_REQ-1:0]   grant_idx_s;
    logic [N_REQ-1:0]     req_hs_s;
    logic [LOG_REQ-1:0]   rsp_sel_s;
    logic                 rsp_sel_ok_s;
    logic [N_REQ-1:0]     resp_valid_s;
    logic [N_REQ-1:0]     rsp_hs_s;
    logic                 mem_rready_s;
    logic                 underflow_s;

    // The output slot can take a new request when empty or when it drains this cycle.
    assign load_s = ~ar_valid_r | mem_arready;

    // A requester is eligible while it has a request and a free MSHR credit;
    // the counter's top bit is set exactly when all 2^LOG_N_MSHR are in use.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible_s[i] = req_valid[i] & ~outstanding_r[i][LOG_N_MSHR];
        end
    end

    // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        int                 idx_v;
        logic [LOG_REQ-1:0] cand_v;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        idx_v         = 0;
        cand_v        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = int'(rr_ptr_r) + k;
            if (idx_v >= N_REQ) begin
                idx_v = idx_v - N_REQ;
            end else begin
                idx_v = idx_v;
            end
            cand_v = idx_v[LOG_REQ-1:0];
            if (!grant_found_s && eligible_s[cand_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Request handshake: ready is raised only for the granted requester, and
    // only when the output slot can load, so ready implies handshake.
    always_comb begin
        req_hs_s = '0;
        if (load_s && grant_found_s) begin
            req_hs_s[grant_idx_s] = 1'b1;
        end else begin
            req_hs_s = '0;
        end
    end

    // Combinational response routing by the requester index in the returned ID.
    always_comb begin
        rsp_sel_s    = mem_rid[ID_W-1 -: LOG_REQ];
        rsp_sel_ok_s = (int'(rsp_sel_s) < N_REQ);
        resp_valid_s = '0;
        rsp_hs_s     = '0;
        mem_rready_s = 1'b1;                       // unknown requester: drop data
        underflow_s  = mem_rvalid & ~rsp_sel_ok_s;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(rsp_sel_s) == i) begin
                resp_valid_s[i] = mem_rvalid;
                mem_rready_s    = resp_ready[i];
                rsp_hs_s[i]     = mem_rvalid & resp_ready[i];
                underflow_s     = mem_rvalid & resp_ready[i] & (outstanding_r[i] == '0);
            end else begin
                resp_valid_s[i] = 1'b0;
            end
        end
    end

    // Output slot for the read-address channel; holds steady while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_valid_r <= 1'b0;
            ar_addr_r  <= '0;
            ar_id_r    <= '0;
        end else if (load_s && grant_found_s) begin
            ar_valid_r <= 1'b1;
            ar_addr_r  <= line_align(req_addr[grant_idx_s*ADDR_BITS +: ADDR_BITS]);
            ar_id_r    <= {grant_idx_s, req_id[grant_idx_s*LOG_N_MSHR +: LOG_N_MSHR]};
        end else if (load_s) begin
            ar_valid_r <= 1'b0;
        end else begin
            ar_valid_r <= ar_valid_r;
        end
    end

    // Round-robin pointer advances past the winner; unchanged without a grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_r <= '0;
        end else if (load_s && grant_found_s) begin
            if (int'(grant_idx_s) == N_REQ - 1) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= grant_idx_s + LOG_REQ'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Per-requester in-flight counters; a response at zero leaves it at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REQ; i++) begin
                outstanding_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_hs_s[i] && !rsp_hs_s[i]) begin
                    outstanding_r[i] <= outstanding_r[i] + CNT_W'(1);
                end else if (!req_hs_s[i] && rsp_hs_s[i] && (outstanding_r[i] != '0)) begin
                    outstanding_r[i] <= outstanding_r[i] - CNT_W'(1);
                end else begin
                    outstanding_r[i] <= outstanding_r[i];
                end
            end
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_r <= 1'b0;
        end else if (underflow_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Saturating count of cycles with a pending request but no acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_r <= 32'd0;
        end else if ((|req_valid) && !(|req_hs_s) && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign req_ready     = req_hs_s;
    assign mem_arvalid   = ar_valid_r;
    assign mem_araddr    = ar_addr_r;
    assign mem_arid      = ar_id_r;
    assign mem_rready    = mem_rready_s;
    assign resp_valid    = resp_valid_s;
    assign resp_id       = mem_rid[LOG_N_MSHR-1:0];
    assign resp_data     = mem_rdata;
    assign err_underflow = err_r;
    assign stall_cycles  = stall_r;

endmodule

// File: tb/tb_l2_fill_arbiter.sv
// Testbench for l2_fill_arbiter: response-routing vector table, directed
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_l2_fill_arbiter;

    localparam int N   = 4;
    localparam int L   = 4;
    localparam int AW  = 34;
    localparam int CBW = 6;
    localparam int DW  = 512;
    localparam int IDW = 6;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*L-1:0]  req_id;
    logic            mem_arvalid;
    logic            mem_arready;
    logic [AW-1:0]   mem_araddr;
    logic [IDW-1:0]  mem_arid;
    logic            mem_rvalid;
    logic            mem_rready;
    logic [IDW-1:0]  mem_rid;
    logic [DW-1:0]   mem_rdata;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [L-1:0]    resp_id;
    logic [DW-1:0]   resp_data;
    logic            err_underflow;
    logic [31:0]     stall_cycles;

    always #5 clk = ~clk;

    l2_fill_arbiter #(
        .N_REQ(N), .LOG_N_MSHR(L), .ADDR_BITS(AW), .CACHE_BYTE_WIDTH(CBW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_id(req_id),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arid(mem_arid), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rid(mem_rid), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .err_underflow(err_underflow), .stall_cycles(stall_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: in-flight counts, pointer, the single output slot.
    int            m_out [N];
    int            m_ptr;
    bit            m_full;
    logic [AW-1:0] m_addr;
    logic [IDW-1:0] m_id;
    bit            m_err;
    longint        m_stall;

    typedef struct {
        logic           rvalid;
        logic [IDW-1:0] rid;
        logic [N-1:0]   rrdy;
        logic [N-1:0]   exp_rv;
        logic           exp_rr;
        logic [L-1:0]   exp_id;
    } rvec_t;

    rvec_t tbl [7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_out[i] = 0;
        m_ptr = 0; m_full = 0; m_addr = '0; m_id = '0; m_err = 0; m_stall = 0;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_addr = '0; req_id = '0; mem_arready = 1'b0;
        mem_rvalid = 1'b0; mem_rid = '0; mem_rdata = '0; resp_ready = '0;
    endtask

    task automatic rand_data();
        for (int w = 0; w < DW / 32; w++) mem_rdata[w*32 +: 32] = $urandom;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        #1;
        check("rst_arvalid", 64'(mem_arvalid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);
        check("rst_stall", 64'(stall_cycles), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    // One clock of traffic with inputs already driven; checks against the model.
    task automatic cycle(output int g);
        int           sel;
        logic         exp_rr;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        bit           rhs;
        bit           inc;
        bit           dec;
        #1;
        g = -1;
        if (!m_full || mem_arready) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (g < 0 && req_valid[i] && m_out[i] < (1 << L)) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        sel    = int'(mem_rid[IDW-1:L]);
        exp_rv = '0;
        exp_rr = 1'b1;
        if (sel < N) begin
            exp_rr      = resp_ready[sel];
            exp_rv[sel] = mem_rvalid;
        end
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("resp_valid", 64'(resp_valid), 64'(exp_rv));
        check("mem_rready", 64'(mem_rready), 64'(exp_rr));
        check("resp_id", 64'(resp_id), 64'(mem_rid[L-1:0]));
        check("resp_data_lo", resp_data[63:0], mem_rdata[63:0]);
        check("resp_data_hi", resp_data[DW-1 -: 64], mem_rdata[DW-1 -: 64]);
        @(posedge clk);
        rhs = mem_rvalid && exp_rr;
        if (rhs && (sel >= N || m_out[sel] == 0)) m_err = 1;
        for (int i = 0; i < N; i++) begin
            inc = (g == i);
            dec = rhs && (sel == i);
            if (inc && !dec) m_out[i]++;
            else if (!inc && dec && m_out[i] > 0) m_out[i]--;
        end
        if (g >= 0) begin
            m_full = 1;
            m_addr = (req_addr[g*AW +: AW] >> CBW) << CBW;
            m_id   = {2'(g), req_id[g*L +: L]};
            m_ptr  = (g + 1) % N;
        end else if (m_full && mem_arready) begin
            m_full = 0;
        end
        if ((|req_valid) && g < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
        #1;
        check("mem_arvalid", 64'(mem_arvalid), 64'(m_full));
        if (m_full) begin
            check("mem_araddr", 64'(mem_araddr), 64'(m_addr));
            check("mem_arid", 64'(mem_arid), 64'(m_id));
        end
        check("err_underflow", 64'(err_underflow), 64'(m_err));
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        @(negedge clk);
    endtask

    int g;
    int order [5];
    int live [$];

    initial begin
        // Response routing vectors, applied while reset holds all state.
        tbl[0] = '{1'b1, 6'h25, 4'b1011, 4'b0100, 1'b0, 4'h5};
        tbl[1] = '{1'b1, 6'h25, 4'b0100, 4'b0100, 1'b1, 4'h5};
        tbl[2] = '{1'b0, 6'h25, 4'b0100, 4'b0000, 1'b1, 4'h5};
        tbl[3] = '{1'b1, 6'h0A, 4'b0001, 4'b0001, 1'b1, 4'hA};
        tbl[4] = '{1'b1, 6'h3F, 4'b0111, 4'b1000, 1'b0, 4'hF};
        tbl[5] = '{1'b1, 6'h1C, 4'b1101, 4'b0010, 1'b0, 4'hC};
        tbl[6] = '{1'b0, 6'h30, 4'b0000, 4'b0000, 1'b0, 4'h0};
        order  = '{0, 1, 2, 3, 0};

        rstn = 1'b0;
        clear_inputs();
        #2;
        for (int v = 0; v < 7; v++) begin
            mem_rvalid = tbl[v].rvalid;
            mem_rid    = tbl[v].rid;
            resp_ready = tbl[v].rrdy;
            rand_data();
            #1;
            check("tbl_resp_valid", 64'(resp_valid), 64'(tbl[v].exp_rv));
            check("tbl_mem_rready", 64'(mem_rready), 64'(tbl[v].exp_rr));
            check("tbl_resp_id", 64'(resp_id), 64'(tbl[v].exp_id));
            check("tbl_resp_data", resp_data[127:64], mem_rdata[127:64]);
        end
        do_reset();

        // Round-robin order with everyone requesting and memory always ready.
        req_valid   = 4'hF;
        mem_arready = 1'b1;
        for (int i = 0; i < N; i++) req_id[i*L +: L] = 4'(i + 8);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", 64'(req_ready), 64'(1) << order[k]);
            cycle(g);
            check("rr_arid_req", 64'(mem_arid[IDW-1:L]), 64'(order[k]));
        end

        // Back-pressure: slot holds requester 2's aligned address while stalled.
        do_reset();
        req_valid = 4'b0100;
        req_addr[2*AW +: AW] = 34'h1_2345_6789;
        req_id[2*L +: L]     = 4'h7;
        cycle(g);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_no_ready", 64'(req_ready), 64'd0);
            cycle(g);
            check("bp_araddr", 64'(mem_araddr), 64'h1_2345_6780);
            check("bp_arvalid", 64'(mem_arvalid), 64'd1);
        end
        check("bp_stall_count", 64'(stall_cycles), 64'd5);
        mem_arready = 1'b1;
        #1;
        check("bp_drain_ready", 64'(req_ready), 64'b0100);
        cycle(g);

        // Outstanding limit: 17th request from requester 1 blocks, 3 still served.
        do_reset();
        mem_arready = 1'b1;
        req_valid   = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            req_id[1*L +: L] = 4'(k);
            #1;
            check("lim_accept", 64'(req_ready[1]), 64'd1);
            cycle(g);
        end
        req_valid = 4'b1010;
        #1;
        check("lim_blocked", 64'(req_ready), 64'b1000);
        cycle(g);
        req_valid  = 4'b0010;
        mem_rvalid = 1'b1;
        mem_rid    = 6'h13;
        resp_ready = 4'b0010;
        #1;
        check("lim_still_full", 64'(req_ready), 64'd0);
        cycle(g);
        mem_rvalid = 1'b0;
        #1;
        check("lim_regrant", 64'(req_ready), 64'b0010);
        cycle(g);

        // Response back-pressure then handshake decrementing requester 2.
        do_reset();
        mem_arready = 1'b1;
        req_valid   = 4'b0100;
        req_id[2*L +: L] = 4'h5;
        cycle(g);
        req_valid  = '0;
        mem_rvalid = 1'b1;
        mem_rid    = 6'h25;
        rand_data();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rsp_bp_valid", 64'(resp_valid), 64'b0100);
            check("rsp_bp_rready", 64'(mem_rready), 64'd0);
            cycle(g);
        end
        resp_ready = 4'b0100;
        #1;
        check("rsp_hs_rready", 64'(mem_rready), 64'd1);
        cycle(g);
        check("rsp_hs_no_err", 64'(err_underflow), 64'd0);
        cycle(g);
        check("rsp_second_err", 64'(err_underflow), 64'd1);

        // Simultaneous request and response for requester 0 keeps count at 3.
        do_reset();
        mem_arready = 1'b1;
        req_valid   = 4'b0001;
        for (int k = 0; k < 3; k++) cycle(g);
        mem_rvalid = 1'b1;
        mem_rid    = 6'h01;
        resp_ready = 4'b0001;
        cycle(g);
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            cycle(g);
            check("same_cyc_no_err", 64'(err_underflow), 64'd0);
        end
        cycle(g);
        check("same_cyc_err", 64'(err_underflow), 64'd1);

        // Underflow on requester 3 is sticky until reset.
        do_reset();
        mem_rvalid = 1'b1;
        mem_rid    = 6'h31;
        resp_ready = 4'hF;
        #1;
        check("uf_valid", 64'(resp_valid), 64'b1000);
        cycle(g);
        check("uf_set", 64'(err_underflow), 64'd1);
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(g);
            check("uf_sticky", 64'(err_underflow), 64'd1);
        end

        // Randomized traffic; phase 0 only answers live requesters, phase 1 is unrestricted.
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                req_valid   = 4'($urandom);
                mem_arready = ($urandom_range(0, 9) < 7);
                for (int i = 0; i < N; i++) begin
                    req_addr[i*AW +: AW] = {2'($urandom), 32'($urandom)};
                    req_id[i*L +: L]     = 4'($urandom);
                end
                resp_ready = 4'($urandom);
                mem_rvalid = ($urandom_range(0, 9) < 4);
                mem_rid    = 6'($urandom);
                if (ph == 0) begin
                    live.delete();
                    for (int i = 0; i < N; i++) if (m_out[i] > 0) live.push_back(i);
                    if (live.size() == 0) mem_rvalid = 1'b0;
                    else mem_rid[IDW-1:L] = 2'(live[$urandom_range(0, live.size() - 1)]);
                end
                rand_data();
                cycle(g);
            end
            if (ph == 0) check("rand_no_err", 64'(err_underflow), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
